// File: rtl/dispatch_steer_pkg.sv
// Shared decode types for the dispatch steering block: queue IDs, decoded
// instruction record and the serialization FSM states.
package dispatch_steer_pkg;

  localparam int DEC_WIDTH_DEF = 4;
  localparam int QUE_NUM_DEF   = 4;

  typedef logic [1:0] que_id_t;

  localparam que_id_t DQ_INT  = 2'd0;
  localparam que_id_t DQ_MEM  = 2'd1;
  localparam que_id_t DQ_MISC = 2'd2;
  localparam que_id_t DQ_FP   = 2'd3;

  typedef struct packed {
    logic [15:0] tag;
    logic        need_serialize;
    que_id_t     dispQue_id;
  } decinfo_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } serState_t;

endpackage

// File: rtl/dispatch_steer_if.sv
// Decode-to-dispatch bundle: decode slots and resource counts in, per-queue
// steered entries out.
interface dispatch_steer_if
  import dispatch_steer_pkg::*;
#(
  parameter int DECWIDTH = DEC_WIDTH_DEF,
  parameter int QUENUM   = QUE_NUM_DEF,
  parameter int CNTW     = $clog2(DECWIDTH + 1)
) ();

  logic                                 i_squash;
  logic [DECWIDTH-1:0]                  i_dec_vld;
  decinfo_t [DECWIDTH-1:0]              i_decinfo;
  logic [DECWIDTH-1:0]                  o_dec_acc;
  logic [CNTW-1:0]                      i_rob_free;
  logic [QUENUM-1:0][CNTW-1:0]          i_que_free;
  logic [QUENUM-1:0][DECWIDTH-1:0]      o_que_vld;
  decinfo_t [QUENUM-1:0][DECWIDTH-1:0]  o_que_info;
  logic [CNTW-1:0]                      o_rob_alloc;
  logic                                 i_serialize_done;
  logic                                 o_serializing;

  modport master (
    output i_squash, i_dec_vld, i_decinfo, i_rob_free, i_que_free, i_serialize_done,
    input  o_dec_acc, o_que_vld, o_que_info, o_rob_alloc, o_serializing
  );

  modport slave (
    input  i_squash, i_dec_vld, i_decinfo, i_rob_free, i_que_free, i_serialize_done,
    output o_dec_acc, o_que_vld, o_que_info, o_rob_alloc, o_serializing
  );

endinterface

// File: rtl/dispatch_steer_compact.sv
// Packs the selected entries of one dispatch queue into its lowest slots,
// keeping program order.
module dispatch_compact
  import dispatch_steer_pkg::*;
#(
  parameter int DECWIDTH = DEC_WIDTH_DEF,
  parameter int CNTW     = $clog2(DECWIDTH + 1)
) (
  input  logic [DECWIDTH-1:0]     sel,
  input  decinfo_t [DECWIDTH-1:0] info,
  output logic [DECWIDTH-1:0]     vld,
  output decinfo_t [DECWIDTH-1:0] packed_info
);

  logic [DECWIDTH-1:0][CNTW-1:0] pre;
  logic [CNTW-1:0]               pos;

  // pre[k] is the number of selected entries older than k, i.e. k's target slot
  always_comb begin
    pos = '0;
    pre = '0;
    for (int k = 0; k < DECWIDTH; k++) begin
      pre[k] = pos;
      pos    = pos + CNTW'(sel[k]);
    end
  end

  // NOTE: every output gets a default before the loop, otherwise a slot with
  // no matching source would hold its old value and infer a latch.
  always_comb begin
    vld         = '0;
    packed_info = '0;
    for (int j = 0; j < DECWIDTH; j++) begin
      for (int k = 0; k < DECWIDTH; k++) begin
        if (sel[k] && pre[k] == CNTW'(j)) begin
          vld[j]         = 1'b1;
          packed_info[j] = info[k];
        end
      end
    end
  end

endmodule

// File: rtl/dispatch_steer.sv
// Accepts the longest in-order decode prefix that fits ROB and queue space,
// steers it to the dispatch queues and runs the serialization FSM.
module dispatch_steer
  import dispatch_steer_pkg::*;
#(
  parameter int DECWIDTH = DEC_WIDTH_DEF,
  parameter int QUENUM   = QUE_NUM_DEF,
  parameter int CNTW     = $clog2(DECWIDTH + 1)
) (
  input logic             clk,
  input logic             rst,
  dispatch_steer_if.slave bus
);

  serState_t state_q, state_d;

  logic [DECWIDTH-1:0]             acc;
  logic [DECWIDTH-1:0]             prev_ser;
  logic [CNTW-1:0]                 n_acc;
  logic [QUENUM-1:0][CNTW-1:0]     q_cnt;
  logic                            ok;

  logic [QUENUM-1:0][DECWIDTH-1:0]     sel;
  logic [QUENUM-1:0][DECWIDTH-1:0]     comp_vld;
  decinfo_t [QUENUM-1:0][DECWIDTH-1:0] comp_info;

  logic [QUENUM-1:0][DECWIDTH-1:0]     que_vld_q;
  decinfo_t [QUENUM-1:0][DECWIDTH-1:0] que_info_q;
  logic [CNTW-1:0]                     rob_alloc_q;

  // A serializing slot blocks everything younger than itself in the same group
  always_comb begin
    prev_ser = '0;
    for (int k = 1; k < DECWIDTH; k++) begin
      prev_ser[k] = bus.i_decinfo[k-1].need_serialize;
    end
  end

  // Walk the slots in program order; the first rejection ends the prefix
  always_comb begin
    acc   = '0;
    n_acc = '0;
    q_cnt = '0;
    ok    = rst && (state_q == IDLE) && !bus.i_squash;
    for (int k = 0; k < DECWIDTH; k++) begin
      ok = ok && bus.i_dec_vld[k]
               && (n_acc < bus.i_rob_free)
               && (q_cnt[bus.i_decinfo[k].dispQue_id]
                   < bus.i_que_free[bus.i_decinfo[k].dispQue_id])
               && (!bus.i_decinfo[k].need_serialize || k == 0)
               && !prev_ser[k];
      if (ok) begin
        acc[k] = 1'b1;
        n_acc  = n_acc + 1'b1;
        q_cnt[bus.i_decinfo[k].dispQue_id] = q_cnt[bus.i_decinfo[k].dispQue_id] + 1'b1;
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int q = 0; q < QUENUM; q++) begin
      for (int k = 0; k < DECWIDTH; k++) begin
        sel[q][k] = acc[k] && (bus.i_decinfo[k].dispQue_id == que_id_t'(q));
      end
    end
  end

  for (genvar q = 0; q < QUENUM; q++) begin : g_que
    dispatch_compact #(
      .DECWIDTH (DECWIDTH),
      .CNTW     (CNTW)
    ) u_compact (
      .sel         (sel[q]),
      .info        (bus.i_decinfo),
      .vld         (comp_vld[q]),
      .packed_info (comp_info[q])
    );
  end

  // Squash wins over serialize_done; acceptance is already zero under squash
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (acc[0] && bus.i_decinfo[0].need_serialize) state_d = WAIT;
      WAIT: if (bus.i_serialize_done || bus.i_squash)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state and the output register use non-blocking assignments so every
  // flop samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the info payload is reset too, since downstream sees zeros while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      que_vld_q   <= '0;
      que_info_q  <= '0;
      rob_alloc_q <= '0;
    end else if (bus.i_squash) begin
      que_vld_q   <= '0;
      que_info_q  <= '0;
      rob_alloc_q <= '0;
    end else begin
      que_vld_q   <= comp_vld;
      que_info_q  <= comp_info;
      rob_alloc_q <= n_acc;
    end
  end

  assign bus.o_dec_acc     = acc;
  assign bus.o_que_vld     = que_vld_q;
  assign bus.o_que_info    = que_info_q;
  assign bus.o_rob_alloc   = rob_alloc_q;
  assign bus.o_serializing = (state_q == WAIT);

endmodule
